// File: rtl/jtdsp16_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : jtdsp16_pkg                                            |
// | Purpose  : Shared types for the DSP16 program/table ROM arbiter:  |
// |            FSM state encoding, wait-state counter type and the    |
// |            internal/external address classification helper.      |
// | Revision : 1.0 - initial release                                  |
// +------------------------------------------------------------------+
package jtdsp16_pkg;

    // Width of the external-ROM wait-state counter (WS ranges 0..7)
    localparam int c_ws_w = 3;

    typedef logic [c_ws_w-1:0] ws_cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_INT      = 2'd1,
        ST_EXT_WAIT = 2'd2
    } arb_state_t;

    // Requester indices used by the round-robin arbiter and ok routing
    localparam int c_req_fetch = 0;
    localparam int c_req_tbl   = 1;

    // Addresses at or above the boundary live in external memory
    function automatic logic addr_is_ext(input logic [15:0] addr,
                                         input logic [15:0] bound);
        return (addr >= bound);
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtdsp16_rom_arb_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : jtdsp16_rom_arb_if                                     |
// | Purpose  : Bundle of requester and ROM-side signals of the ROM    |
// |            arbiter. 'slave' is the arbiter view, 'master' is the  |
// |            view of the environment (requesters plus ROM).         |
// | Revision : 1.0 - initial release                                  |
// +------------------------------------------------------------------+
interface jtdsp16_rom_arb_if;

    logic        cen;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        fetch_ok;
    logic        tbl_req;
    logic [15:0] tbl_addr;
    logic        tbl_ok;
    logic [15:0] rd_data;
    logic [15:0] rom_addr;
    logic        rom_cs;
    logic        rom_ext;
    logic [15:0] rom_data;
    logic        rom_ok;

    modport slave (
        input  cen, fetch_req, fetch_addr, tbl_req, tbl_addr, rom_data, rom_ok,
        output fetch_ok, tbl_ok, rd_data, rom_addr, rom_cs, rom_ext
    );

    modport master (
        output cen, fetch_req, fetch_addr, tbl_req, tbl_addr, rom_data, rom_ok,
        input  fetch_ok, tbl_ok, rd_data, rom_addr, rom_cs, rom_ext
    );

endinterface
`default_nettype wire

// File: rtl/jtdsp16_rr2.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : jtdsp16_rr2                                            |
// | Purpose  : Two-input round-robin arbiter. Grant is combinational  |
// |            from the request lines and the last-grant register;    |
// |            the register moves only when the grant is taken.       |
// | Revision : 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module jtdsp16_rr2 (
    input  wire logic       clk,
    input  wire logic       rst,     // synchronous, active low
    input  wire logic       i_cen,
    input  wire logic [1:0] i_req,
    input  wire logic       i_take,
    output logic      [1:0] o_gnt,
    output logic            o_last   // 1: requester 1 was granted last
);

    logic r_last;

    // A lone requester wins; on a tie the one not served last wins
    always_comb begin
        o_gnt[0] = i_req[0] & (~i_req[1] |  r_last);
        o_gnt[1] = i_req[1] & (~i_req[0] | ~r_last);
    end

    // Remember who was granted; reset favours requester 1 on the first tie
    always_ff @(posedge clk) begin
        if (!rst)
            r_last <= 1'b0;
        else if (i_cen && i_take)
            r_last <= o_gnt[1];
    end

    assign o_last = r_last;

endmodule
`default_nettype wire

// File: rtl/jtdsp16_rom_arb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : jtdsp16_rom_arb                                        |
// | Purpose  : Shares one ROM port between instruction fetch and      |
// |            table reads. Internal accesses take one cen cycle,     |
// |            external ones WS cycles plus the rom_ok handshake.     |
// |            A completing access can hand over to the next request  |
// |            in the same cycle.                                     |
// | Revision : 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module jtdsp16_rom_arb
    import jtdsp16_pkg::*;
#(
    parameter int          WS        = 2,
    parameter logic [15:0] EXT_BOUND = 16'h1000
) (
    input wire logic          clk,
    input wire logic          rst,   // synchronous, active low
    jtdsp16_rom_arb_if.slave  bus
);

    localparam ws_cnt_t c_ws_load = ws_cnt_t'(WS);

    arb_state_t  r_state,    w_state;
    ws_cnt_t     r_cnt,      w_cnt;
    logic [15:0] r_rom_addr, w_rom_addr;
    logic        r_rom_cs,   w_rom_cs;
    logic        r_rom_ext,  w_rom_ext;
    logic [15:0] r_rd_data,  w_rd_data;
    logic        r_fetch_ok, w_fetch_ok;
    logic        r_tbl_ok,   w_tbl_ok;

    logic [1:0]  w_req;
    logic [1:0]  w_gnt;
    logic        w_last;     // owner of the access in progress (1: table)
    logic        w_take;
    logic        w_done;
    logic [15:0] w_sel_addr;

    assign w_req = {bus.tbl_req, bus.fetch_req};

    jtdsp16_rr2 u_rr2 (
        .clk    (clk),
        .rst    (rst),
        .i_cen  (bus.cen),
        .i_req  (w_req),
        .i_take (w_take),
        .o_gnt  (w_gnt),
        .o_last (w_last)
    );

    // Next-state: finish the current access, then grant the next one if any
    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_rom_addr = r_rom_addr;
        w_rom_cs   = r_rom_cs;
        w_rom_ext  = r_rom_ext;
        w_rd_data  = r_rd_data;
        w_fetch_ok = 1'b0;
        w_tbl_ok   = 1'b0;
        w_done     = 1'b0;
        w_take     = 1'b0;
        w_sel_addr = w_gnt[c_req_tbl] ? bus.tbl_addr : bus.fetch_addr;

        case (r_state)
            ST_IDLE: ;
            ST_INT:  w_done = 1'b1;
            ST_EXT_WAIT: begin
                // Wait states elapse first; then the access lasts until rom_ok
                if (r_cnt == '0)
                    w_done = bus.rom_ok;
                else
                    w_cnt = r_cnt - 1'b1;
            end
            default: w_state = ST_IDLE;
        endcase

        if (w_done) begin
            w_rd_data  = bus.rom_data;
            w_fetch_ok = ~w_last;
            w_tbl_ok   =  w_last;
            w_state    = ST_IDLE;
            w_rom_cs   = 1'b0;
            w_rom_ext  = 1'b0;
        end

        // Addresses are captured only here, so later changes are ignored
        if ((r_state == ST_IDLE || w_done) && (|w_gnt)) begin
            w_take     = 1'b1;
            w_rom_addr = w_sel_addr;
            w_rom_cs   = 1'b1;
            w_rom_ext  = addr_is_ext(w_sel_addr, EXT_BOUND);
            w_state    = w_rom_ext ? ST_EXT_WAIT : ST_INT;
            w_cnt      = w_rom_ext ? c_ws_load : '0;
        end
    end

    // State and output registers; reset wins over cen
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_rom_addr <= '0;
            r_rom_cs   <= 1'b0;
            r_rom_ext  <= 1'b0;
            r_rd_data  <= '0;
            r_fetch_ok <= 1'b0;
            r_tbl_ok   <= 1'b0;
        end else if (bus.cen) begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_rom_addr <= w_rom_addr;
            r_rom_cs   <= w_rom_cs;
            r_rom_ext  <= w_rom_ext;
            r_rd_data  <= w_rd_data;
            r_fetch_ok <= w_fetch_ok;
            r_tbl_ok   <= w_tbl_ok;
        end
    end

    assign bus.rom_addr = r_rom_addr;
    assign bus.rom_cs   = r_rom_cs;
    assign bus.rom_ext  = r_rom_ext;
    assign bus.rd_data  = r_rd_data;
    assign bus.fetch_ok = r_fetch_ok;
    assign bus.tbl_ok   = r_tbl_ok;

endmodule
`default_nettype wire

// File: tb/tb_jtdsp16_rom_arb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_jtdsp16_rom_arb                                     |
// | Purpose  : Self-checking bench for jtdsp16_rom_arb: directed      |
// |            scenarios with literal expectations plus a             |
// |            transaction-level reference model compared each cycle. |
// | Revision : 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module tb_jtdsp16_rom_arb;

    localparam int          c_ws    = 2;
    localparam logic [15:0] c_bound = 16'h1000;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    bit   check_en = 1'b0;
    int   lat;

    jtdsp16_rom_arb_if bus ();

    jtdsp16_rom_arb #(.WS(c_ws), .EXT_BOUND(c_bound)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ROM contents seen by the arbiter
    function automatic logic [15:0] rom_fn(input logic [15:0] a);
        return (a == 16'h0123) ? 16'hBEEF : (a ^ 16'hA5C3);
    endfunction

    assign bus.rom_data = rom_fn(bus.rom_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // ---------------- reference model (one access in flight) ----------------
    bit          m_busy = 0;
    bit          m_who  = 0;      // 1: table read
    logic [15:0] m_addr = '0;
    bit          m_ext  = 0;
    int          m_wait = 0;      // wait states still to elapse
    bit          m_last = 0;
    bit          e_fok = 0, e_tok = 0;
    logic [15:0] e_rd = '0;
    bit          m_done;

    always @(posedge clk) begin
        if (!rst) begin
            m_busy = 0; m_who = 0; m_addr = '0; m_ext = 0; m_wait = 0; m_last = 0;
            e_fok = 0; e_tok = 0; e_rd = '0;
        end else if (bus.cen) begin
            e_fok = 0;
            e_tok = 0;
            m_done = m_busy && (!m_ext || (m_wait == 0 && bus.rom_ok));
            if (m_done) begin
                e_rd   = rom_fn(m_addr);
                e_tok  = m_who;
                e_fok  = !m_who;
                m_busy = 0;
            end else if (m_busy && m_wait > 0) begin
                m_wait--;
            end
            if (!m_busy && (bus.fetch_req || bus.tbl_req)) begin
                m_who  = (bus.fetch_req && bus.tbl_req) ? !m_last : bus.tbl_req;
                m_last = m_who;
                m_addr = m_who ? bus.tbl_addr : bus.fetch_addr;
                m_ext  = (m_addr >= c_bound);
                m_wait = m_ext ? c_ws : 0;
                m_busy = 1;
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (check_en) begin
            chk("m_fetch_ok", bus.fetch_ok, e_fok);
            chk("m_tbl_ok",   bus.tbl_ok,   e_tok);
            chk("m_rd_data",  bus.rd_data,  e_rd);
            chk("m_rom_cs",   bus.rom_cs,   m_busy);
            chk("m_ok_excl",  bus.fetch_ok & bus.tbl_ok, 0);
            if (m_busy) begin
                chk("m_rom_addr", bus.rom_addr, m_addr);
                chk("m_rom_ext",  bus.rom_ext,  m_ext);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 0; bus.cen = 1; bus.rom_ok = 1;
        bus.fetch_req = 0; bus.tbl_req = 0; bus.fetch_addr = '0; bus.tbl_addr = '0;
        tick(); check_en = 1;
        tick();
        chk("rst_cs",   bus.rom_cs,   0);
        chk("rst_ext",  bus.rom_ext,  0);
        chk("rst_addr", bus.rom_addr, 0);
        chk("rst_rd",   bus.rd_data,  0);
        chk("rst_oks",  {bus.fetch_ok, bus.tbl_ok}, 0);

        // Single internal fetch
        rst = 1; bus.fetch_addr = 16'h0123; bus.fetch_req = 1;
        tick();
        chk("f_grant_cs",   bus.rom_cs,   1);
        chk("f_grant_addr", bus.rom_addr, 16'h0123);
        chk("f_grant_ok",   bus.fetch_ok, 0);
        bus.fetch_req = 0;
        tick();
        chk("f_ok",   bus.fetch_ok, 1);
        chk("f_data", bus.rd_data,  16'hBEEF);
        tick();
        chk("f_ok_end",  bus.fetch_ok, 0);
        chk("f_cs_end",  bus.rom_cs,   0);
        chk("f_rd_hold", bus.rd_data,  16'hBEEF);

        // Tie after reset: table first, then fetch back-to-back
        rst = 0; tick(); rst = 1;
        bus.fetch_addr = 16'h0010; bus.tbl_addr = 16'h0020;
        bus.fetch_req = 1; bus.tbl_req = 1;
        tick();
        chk("tie_first", bus.rom_addr, 16'h0020);
        bus.tbl_req = 0;
        tick();
        chk("tie_tbl_ok",  bus.tbl_ok,   1);
        chk("tie_tbl_rd",  bus.rd_data,  16'h0020 ^ 16'hA5C3);
        chk("tie_second",  bus.rom_addr, 16'h0010);
        bus.fetch_req = 0;
        tick();
        chk("tie_fetch_ok", {bus.fetch_ok, bus.tbl_ok}, 2'b10);
        chk("tie_fetch_rd", bus.rd_data, 16'h0010 ^ 16'hA5C3);
        // Both held: alternating grants, checked by the model
        bus.fetch_req = 1; bus.tbl_req = 1;
        repeat (6) tick();
        bus.fetch_req = 0; bus.tbl_req = 0;
        repeat (2) tick();

        // External table read, rom_ok high
        bus.tbl_addr = 16'h2000; bus.tbl_req = 1; bus.rom_ok = 1;
        tick();
        chk("ext_flag", bus.rom_ext, 1);
        bus.tbl_req = 0;
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (bus.tbl_ok) begin lat = i; break; end
        end
        chk("ext_latency", lat, c_ws + 1);
        chk("ext_data", bus.rd_data, 16'h2000 ^ 16'hA5C3);
        tick();

        // External table read, rom_ok low four extra cycles
        bus.rom_ok = 0; bus.tbl_req = 1;
        tick();
        bus.tbl_req = 0;
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (bus.tbl_ok) begin lat = i; break; end
            bus.rom_ok = (i >= 6);
        end
        chk("ext_latency_stall", lat, c_ws + 1 + 4);
        bus.rom_ok = 1;
        tick();

        // cen toggling during an external access at the exact boundary
        bus.tbl_addr = 16'h1000; bus.tbl_req = 1;
        tick();
        chk("bound_ext", bus.rom_ext, 1);
        bus.tbl_req = 0;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            bus.cen = (i % 2 == 0);
            tick();
            if (bus.cen) lat++;
            else chk("cen0_cs_hold", bus.rom_cs, 1);
            if (bus.tbl_ok) break;
        end
        chk("cen_latency", lat, c_ws + 1);
        bus.cen = 0;
        tick();
        chk("cen0_ok_hold", bus.tbl_ok, 1);
        bus.cen = 1;
        tick();
        chk("cen1_ok_clear", bus.tbl_ok, 0);

        // Just below the boundary is internal
        bus.fetch_addr = 16'h0FFF; bus.fetch_req = 1;
        tick();
        chk("bound_int", bus.rom_ext, 0);
        bus.fetch_req = 0;
        repeat (2) tick();

        // Reset in the middle of an external wait
        bus.tbl_addr = 16'h4000; bus.tbl_req = 1;
        tick();
        bus.tbl_req = 0;
        tick();
        rst = 0;
        tick();
        chk("mid_rst_all", {bus.rom_cs, bus.rom_ext, bus.fetch_ok, bus.tbl_ok}, 0);
        chk("mid_rst_addr", bus.rom_addr, 0);
        chk("mid_rst_rd",   bus.rd_data,  0);
        rst = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("no_ok_after_rst", {bus.fetch_ok, bus.tbl_ok}, 0);
        end

        // Address change during service; a table request dropped before grant
        bus.fetch_addr = 16'h3000; bus.fetch_req = 1;
        tick();
        bus.fetch_addr = 16'h0005; bus.fetch_req = 0;
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            bus.tbl_req = (i == 1);
            tick();
            if (bus.fetch_ok) begin lat = i; break; end
            chk("addr_frozen", bus.rom_addr, 16'h3000);
        end
        chk("frozen_latency", lat, c_ws + 1);
        chk("frozen_data", bus.rd_data, 16'h3000 ^ 16'hA5C3);
        bus.tbl_req = 0;
        repeat (2) tick();

        // Mixed directed pattern: contention, stalls and cen gaps
        for (int i = 0; i < 48; i++) begin
            bus.fetch_req  = (i % 5) != 0;
            bus.tbl_req    = (i % 3) != 1;
            bus.fetch_addr = 16'(i * 16'h0155);
            bus.tbl_addr   = 16'(16'h0F00 + i * 16'h0040);
            bus.rom_ok     = (i % 4) != 2;
            bus.cen        = (i % 7) != 3;
            tick();
        end
        bus.fetch_req = 0; bus.tbl_req = 0; bus.rom_ok = 1; bus.cen = 1;
        repeat (8) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jtdsp16_rom_arb.md
JTDSP16_ROM_ARB -- requirements
Module: jtdsp16_rom_arb

Interface
REQ-001 SHALL have parameter WS, default 2: wait states for external ROM accesses (0..7).
REQ-002 SHALL have parameter EXT_BOUND, default 16'h1000: addresses >= EXT_BOUND are external; addresses below it are internal 4K ROM.
REQ-003 SHALL have port clk, input, 1: system clock; one clock, all state on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-low (asserted when 0).
REQ-005 SHALL have port cen, input, 1: clock enable; all state advances only when cen=1.
REQ-006 SHALL have port fetch_req, input, 1: instruction-fetch request (level).
REQ-007 SHALL have port fetch_addr, input, 16: fetch address.
REQ-008 SHALL have port fetch_ok, output, 1: fetch data valid strobe.
REQ-009 SHALL have port tbl_req, input, 1: table-read request (level).
REQ-010 SHALL have port tbl_addr, input, 16: table-read address.
REQ-011 SHALL have port tbl_ok, output, 1: table data valid strobe.
REQ-012 SHALL have port rd_data, output, 16: read data shared by both requesters.
REQ-013 SHALL have port rom_addr, output, 16: address to ROM.
REQ-014 SHALL have port rom_cs, output, 1: ROM access active.
REQ-015 SHALL have port rom_ext, output, 1: current access targets external memory.
REQ-016 SHALL have port rom_data, input, 16: ROM read data.
REQ-017 SHALL have port rom_ok, input, 1: external memory ready; ignored for internal accesses.

Function
REQ-018 SHALL implement FSM IDLE, INT, EXT_WAIT, with every transition qualified by cen=1.
REQ-019 In IDLE with any request pending, SHALL grant one requester, latch its address into rom_addr, set rom_cs=1 and rom_ext=(addr>=EXT_BOUND), and enter INT or EXT_WAIT.
REQ-020 Arbitration SHALL grant a lone requester; when both request, SHALL grant the one not served last (round-robin); after reset, last=fetch, so tbl wins the first tie.
REQ-021 INT: on the next cen cycle SHALL register rom_data into rd_data and pulse the granted ok for exactly one cen cycle.
REQ-022 EXT_WAIT: SHALL load wait counter with WS at grant, decrement per cen cycle, and complete when counter==0 and rom_ok=1; rom_ok=0 at zero SHALL extend the access indefinitely.
REQ-023 Internal latency SHALL be 1 cen cycle grant->ok; external latency SHALL be WS+1 cen cycles with rom_ok held high.
REQ-024 In a completion cycle with a request pending, SHALL grant the next access in the same cycle (back-to-back, 1 internal access per cen cycle); otherwise SHALL return to IDLE with rom_cs=0.
REQ-025 Requester addresses SHALL be sampled only at grant; changes while waiting or in service SHALL be ignored.
REQ-026 A request dropped before grant SHALL cause no access; a request dropped after grant SHALL still complete and pulse ok.
REQ-027 A requester still holding req in the cycle its ok pulses SHALL be treated as a new request.
REQ-028 rd_data SHALL hold its last value between accesses.
REQ-029 fetch_ok and tbl_ok SHALL never be high together.
REQ-030 With cen=0, outputs SHALL hold and the wait counter SHALL not decrement.

Reset
REQ-031 With rst=0 at a clock edge, regardless of cen: state=IDLE, fetch_ok=0, tbl_ok=0, rom_cs=0, rom_ext=0, rom_addr=0, rd_data=0, counter=0, last=fetch.
REQ-032 Reset mid-access SHALL abort the access with no ok pulse after reset release.

Structure
REQ-033 FSM state encodings and WS counter width (3 bits) SHALL live in shared package jtdsp16_pkg.
REQ-034 Round-robin grant logic SHALL be sub-module jtdsp16_rr2 (2-input arbiter, last-grant register).

Verification
REQ-035 Fetch only, fetch_addr=16'h0123, rom_data=16'hBEEF -> rom_cs next cycle, fetch_ok one cycle later, rd_data=16'hBEEF.
REQ-036 Both request at once after reset, internal addrs -> tbl granted first, fetch next cycle (back-to-back), ok strobes on consecutive cycles, never overlapping.
REQ-037 WS=2, tbl_addr=16'h2000, rom_ok=1 -> rom_ext=1, tbl_ok 3 cen cycles after grant; repeat with rom_ok low 4 extra cycles -> tbl_ok delayed by 4.
REQ-038 cen toggling 1/0 during external access -> latency counted in cen cycles only, outputs frozen when cen=0.
REQ-039 rst=0 during EXT_WAIT -> all outputs 0 next edge, no ok after release; fetch_addr changed mid-service -> rom_addr unchanged.
